// File: rtl/reg_bank_banked.sv
// reg_bank_banked: general register file with PC, banked SP and LR, two registered read
// ports, one commit write port and a small mode-switch sequencer with a busy handshake.
// Optional feature: define REGBANK_BYPASS_EN to forward committing values to the read
// ports on the same edge; when undefined, reads always return the pre-edge contents.
// PC lives in entry PC_INDEX and the user-mode SP (bank 0) lives in entry SP_INDEX of the
// register array; the privileged SP (bank 1) is a separate register.
module reg_bank_banked #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned PC_INDEX   = 15,
  parameter int unsigned SP_INDEX   = 14,
  parameter int unsigned LR_INDEX   = 13,
  parameter logic [DATA_WIDTH-1:0] R0_RESET = DATA_WIDTH'(8192),
  parameter logic [DATA_WIDTH-1:0] PC_RESET = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] SP_RESET = '1,
  localparam int unsigned ADDR_BITS = $clog2(REG_COUNT)
) (
  input  logic                  fast_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode_cmd,
  input  logic [ADDR_BITS-1:0]  rd_addr_a,
  input  logic [ADDR_BITS-1:0]  rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  branch,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic [DATA_WIDTH-1:0] pc_next,
  input  logic [DATA_WIDTH-1:0] sp_next,
  output logic [DATA_WIDTH-1:0] current_pc,
  output logic [DATA_WIDTH-1:0] current_sp,
  output logic                  privileged,
  output logic                  busy,
  output logic                  illegal_write
);

  localparam logic [ADDR_BITS-1:0] PC_ADDR = ADDR_BITS'(PC_INDEX);
  localparam logic [ADDR_BITS-1:0] SP_ADDR = ADDR_BITS'(SP_INDEX);
  localparam logic [ADDR_BITS-1:0] LR_ADDR = ADDR_BITS'(LR_INDEX);
  localparam logic [ADDR_BITS-1:0] R0_ADDR = '0;

  localparam logic [1:0] CmdNone  = 2'd0;
  localparam logic [1:0] CmdEnter = 2'd1;
  localparam logic [1:0] CmdExit  = 2'd2;
  localparam logic [1:0] CmdClear = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StEnterSave,
    StEnterSwitch,
    StExitSwap
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [DATA_WIDTH-1:0] sp_priv_q, sp_priv_d;
  logic                  privileged_q, privileged_d;
  logic                  illegal_q, illegal_d;
  logic [DATA_WIDTH-1:0] rd_a_d, rd_b_d;

  // Values the read ports look at (pre-edge, or post-commit when forwarding).
  logic [DATA_WIDTH-1:0] view_regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] view_sp_priv;

  logic commit;
  logic wr_protected;
  logic [DATA_WIDTH-1:0] sp_commit_val;

  assign busy          = (state_q != StIdle);
  assign commit        = enable & ~busy;
  assign wr_protected  = (wr_addr == PC_ADDR) || (wr_addr == SP_ADDR);
  assign sp_commit_val = (mode_cmd == CmdClear) ? SP_RESET : sp_next;

  // Mode sequencer: next state and privilege flag.
  always_comb begin
    state_d      = state_q;
    privileged_d = privileged_q;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          // Entering while privileged, or exiting while user, commits without a sequence.
          if (mode_cmd == CmdEnter && !privileged_q) begin
            state_d = StEnterSave;
          end else if (mode_cmd == CmdExit && privileged_q) begin
            state_d = StExitSwap;
          end
        end
      end
      StEnterSave: begin
        state_d = StEnterSwitch;
      end
      StEnterSwitch: begin
        privileged_d = 1'b1;
        state_d      = StIdle;
      end
      StExitSwap: begin
        privileged_d = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register array next state: commit updates, clear-stack overrides and LR save.
  always_comb begin
    regs_d    = regs_q;
    sp_priv_d = sp_priv_q;
    illegal_d = 1'b0;
    if (commit) begin
      regs_d[PC_ADDR] = branch ? branch_target : pc_next;
      // Only the active SP bank is written; the other bank is left untouched.
      if (privileged_q) begin
        sp_priv_d = sp_commit_val;
      end else begin
        regs_d[SP_ADDR] = sp_commit_val;
      end
      if (wr_en) begin
        if (wr_protected) begin
          illegal_d = 1'b1;
        end else begin
          regs_d[wr_addr] = wr_data;
        end
      end
      if (mode_cmd == CmdClear) begin
        regs_d[R0_ADDR] = R0_RESET;
      end
    end
    // Runs a cycle after the entering commit, so it overwrites any LR write from that commit.
    if (state_q == StEnterSave) begin
      regs_d[LR_ADDR] = regs_q[PC_ADDR];
    end
  end

`ifdef REGBANK_BYPASS_EN
  // Forward only what the current commit writes; sequencer-side updates are not forwarded.
  always_comb begin
    view_regs    = commit ? regs_d : regs_q;
    view_sp_priv = commit ? sp_priv_d : sp_priv_q;
  end
`else
  // Reads observe the state as it was before the edge.
  always_comb begin
    view_regs    = regs_q;
    view_sp_priv = sp_priv_q;
  end
`endif

  // Read port muxes; SP_INDEX resolves to the bank of the current mode.
  always_comb begin
    rd_a_d = view_regs[rd_addr_a];
    rd_b_d = view_regs[rd_addr_b];
    if (rd_addr_a == SP_ADDR && privileged_q) begin
      rd_a_d = view_sp_priv;
    end
    if (rd_addr_b == SP_ADDR && privileged_q) begin
      rd_b_d = view_sp_priv;
    end
  end

  // State registers with synchronous reset; reset mid-sequence returns to user mode.
  always_ff @(posedge fast_clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= (ADDR_BITS'(i) == R0_ADDR) ? R0_RESET :
                     (ADDR_BITS'(i) == PC_ADDR) ? PC_RESET :
                     (ADDR_BITS'(i) == SP_ADDR) ? SP_RESET : '0;
      end
      sp_priv_q    <= SP_RESET;
      state_q      <= StIdle;
      privileged_q <= 1'b0;
      illegal_q    <= 1'b0;
      rd_data_a    <= '0;
      rd_data_b    <= '0;
    end else begin
      regs_q       <= regs_d;
      sp_priv_q    <= sp_priv_d;
      state_q      <= state_d;
      privileged_q <= privileged_d;
      illegal_q    <= illegal_d;
      rd_data_a    <= rd_a_d;
      rd_data_b    <= rd_b_d;
    end
  end

  // Architectural outputs straight from state.
  always_comb begin
    current_pc    = regs_q[PC_ADDR];
    current_sp    = privileged_q ? sp_priv_q : regs_q[SP_ADDR];
    privileged    = privileged_q;
    illegal_write = illegal_q;
  end

endmodule

// File: tb/tb_reg_bank_banked.sv
// Scoreboard bench for reg_bank_banked: stimulus pushes expected values tagged with the
// cycle at which they must appear; a negedge monitor compares and retires them.
module tb_reg_bank_banked;

  localparam int DW = 32;
  localparam int AW = 4;

  localparam int SIG_PC   = 0;
  localparam int SIG_SP   = 1;
  localparam int SIG_PRIV = 2;
  localparam int SIG_BUSY = 3;
  localparam int SIG_ILL  = 4;
  localparam int SIG_RDA  = 5;
  localparam int SIG_RDB  = 6;

  logic          fast_clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode_cmd;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          branch;
  logic [DW-1:0] branch_target, pc_next, sp_next;
  logic [DW-1:0] current_pc, current_sp;
  logic          privileged, busy, illegal_write;

  reg_bank_banked dut (
    .fast_clock    (fast_clock),
    .reset         (reset),
    .enable        (enable),
    .mode_cmd      (mode_cmd),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .branch        (branch),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .sp_next       (sp_next),
    .current_pc    (current_pc),
    .current_sp    (current_sp),
    .privileged    (privileged),
    .busy          (busy),
    .illegal_write (illegal_write)
  );

  always #5 fast_clock = ~fast_clock;

  // Number of rising edges seen so far; stable at the falling edge.
  int cyc = 0;
  always @(posedge fast_clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic expect_at(input int d, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.at   = cyc + d;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      SIG_PC:   return current_pc;
      SIG_SP:   return current_sp;
      SIG_PRIV: return {31'd0, privileged};
      SIG_BUSY: return {31'd0, busy};
      SIG_ILL:  return {31'd0, illegal_write};
      SIG_RDA:  return rd_data_a;
      default:  return rd_data_b;
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle.
  always @(negedge fast_clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        logic [31:0] act;
        act = sample(sb[i].sig);
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(negedge fast_clock);
  endtask

  task automatic idle_inputs();
    enable   = 1'b0;
    mode_cmd = 2'd0;
    wr_en    = 1'b0;
    branch   = 1'b0;
  endtask

  initial begin
    logic [31:0] byp_a5, byp_sp, byp_r0;
`ifdef REGBANK_BYPASS_EN
    byp_a5 = 32'hA5A5_A5A5;
    byp_sp = 32'h100;
    byp_r0 = 32'd8192;
`else
    byp_a5 = 32'h0;
    byp_sp = 32'hFFFF_FFFF;
    byp_r0 = 32'd7;
`endif
    reset = 1'b1;
    idle_inputs();
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd14;
    wr_addr = '0;
    wr_data = '0;
    branch_target = '0;
    pc_next = '0;
    sp_next = '0;

    // Reset state.
    tick();
    expect_at(1, SIG_PC,   32'd1,         "rst_pc");
    expect_at(1, SIG_SP,   32'hFFFF_FFFF, "rst_sp");
    expect_at(1, SIG_BUSY, 32'd0,         "rst_busy");
    expect_at(1, SIG_PRIV, 32'd0,         "rst_priv");
    expect_at(1, SIG_ILL,  32'd0,         "rst_ill");
    expect_at(1, SIG_RDA,  32'd0,         "rst_rda");
    tick();
    reset = 1'b0;
    expect_at(1, SIG_RDA, 32'd8192,      "r0_reset");
    expect_at(1, SIG_RDB, 32'hFFFF_FFFF, "sp_read");
    tick();

    // Write r3, read same edge then next cycle.
    enable = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5_A5A5;
    pc_next = 32'h2; sp_next = 32'hFFFF_FFFF; rd_addr_a = 4'd3;
    expect_at(1, SIG_RDA, byp_a5, "r3_same_edge");
    expect_at(1, SIG_PC,  32'h2,  "pc_seq");
    expect_at(1, SIG_ILL, 32'd0,  "legal_wr");
    tick();
    idle_inputs();
    expect_at(1, SIG_RDA, 32'hA5A5_A5A5, "r3_read");
    tick();

    // Enter privileged mode.
    enable = 1'b1; mode_cmd = 2'd1; pc_next = 32'h20; sp_next = 32'hFFFF_FFFF;
    rd_addr_b = 4'd13;
    expect_at(1, SIG_PC,   32'h20, "enter_pc");
    expect_at(1, SIG_BUSY, 32'd1,  "enter_busy1");
    tick();
    idle_inputs();
    expect_at(1, SIG_BUSY, 32'd1,         "enter_busy2");
    expect_at(1, SIG_PRIV, 32'd0,         "enter_priv_mid");
    expect_at(2, SIG_BUSY, 32'd0,         "enter_done");
    expect_at(2, SIG_PRIV, 32'd1,         "enter_priv");
    expect_at(2, SIG_SP,   32'hFFFF_FFFF, "priv_sp_rst");
    expect_at(2, SIG_RDB,  32'h20,        "lr_saved");
    tick();
    tick();

    // Privileged SP write leaves user SP alone.
    enable = 1'b1; pc_next = 32'h24; sp_next = 32'h100; rd_addr_b = 4'd14;
    expect_at(1, SIG_SP,  32'h100, "priv_sp_wr");
    expect_at(1, SIG_PC,  32'h24,  "priv_pc");
    expect_at(1, SIG_RDB, byp_sp,  "sp_same_edge");
    tick();
    idle_inputs();
    expect_at(1, SIG_RDB, 32'h100, "priv_sp_read");
    tick();

    // Exit privileged mode.
    enable = 1'b1; mode_cmd = 2'd2; pc_next = 32'h28; sp_next = 32'h100;
    expect_at(1, SIG_BUSY, 32'd1,   "exit_busy");
    expect_at(1, SIG_PRIV, 32'd1,   "exit_priv_mid");
    expect_at(1, SIG_PC,   32'h28,  "exit_pc");
    tick();
    idle_inputs();
    expect_at(1, SIG_BUSY, 32'd0,         "exit_done");
    expect_at(1, SIG_PRIV, 32'd0,         "exit_priv");
    expect_at(1, SIG_SP,   32'hFFFF_FFFF, "user_sp_kept");
    tick();

    // Exit while already user: plain commit.
    enable = 1'b1; mode_cmd = 2'd2; pc_next = 32'h2C; sp_next = 32'hFFFF_FFFF;
    expect_at(1, SIG_BUSY, 32'd0,  "exit_user_nobusy");
    expect_at(1, SIG_PC,   32'h2C, "exit_user_pc");
    tick();

    // Illegal writes to PC and SP.
    mode_cmd = 2'd0; wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h55; pc_next = 32'h30;
    expect_at(1, SIG_ILL, 32'd1,  "ill_pc_pulse");
    expect_at(1, SIG_PC,  32'h30, "ill_pc_dropped");
    tick();
    idle_inputs();
    expect_at(1, SIG_ILL, 32'd0,  "ill_pulse_end");
    tick();
    enable = 1'b1; wr_en = 1'b1; wr_addr = 4'd14; wr_data = 32'h77;
    sp_next = 32'h200; pc_next = 32'h34;
    expect_at(1, SIG_ILL, 32'd1,   "ill_sp_pulse");
    expect_at(1, SIG_SP,  32'h200, "ill_sp_dropped");
    tick();
    idle_inputs();

    // Enable held through busy.
    enable = 1'b1; mode_cmd = 2'd1; pc_next = 32'h40; sp_next = 32'h200;
    expect_at(1, SIG_PC, 32'h40, "hold_commit");
    tick();
    mode_cmd = 2'd0; pc_next = 32'h99; sp_next = 32'h300;
    expect_at(1, SIG_PC,   32'h40,  "hold_pc1");
    expect_at(1, SIG_BUSY, 32'd1,   "hold_busy");
    expect_at(2, SIG_PC,   32'h40,  "hold_pc2");
    expect_at(2, SIG_SP,   32'h100, "hold_priv_sp");
    expect_at(2, SIG_PRIV, 32'd1,   "hold_priv");
    tick();
    tick();
    idle_inputs();

    // Exit, then reset during ENTER_SAVE.
    enable = 1'b1; mode_cmd = 2'd2; pc_next = 32'h44; sp_next = 32'h100;
    tick();
    idle_inputs();
    tick();
    enable = 1'b1; mode_cmd = 2'd1; pc_next = 32'h48; sp_next = 32'h200;
    expect_at(1, SIG_BUSY, 32'd1, "pre_rst_busy");
    tick();
    idle_inputs();
    reset = 1'b1;
    expect_at(1, SIG_BUSY, 32'd0,         "midrst_busy");
    expect_at(1, SIG_PRIV, 32'd0,         "midrst_priv");
    expect_at(1, SIG_PC,   32'd1,         "midrst_pc");
    expect_at(1, SIG_SP,   32'hFFFF_FFFF, "midrst_sp");
    tick();
    reset = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd13;
    expect_at(1, SIG_BUSY, 32'd0, "post_rst_idle");
    expect_at(1, SIG_PRIV, 32'd0, "post_rst_user");
    expect_at(1, SIG_RDA,  32'd0, "post_rst_r3");
    expect_at(1, SIG_RDB,  32'd0, "post_rst_lr");
    tick();

    // Clear stack overrides sp_next and the R0 write.
    enable = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'd7;
    sp_next = 32'h40; pc_next = 32'h50; rd_addr_a = 4'd0;
    expect_at(1, SIG_SP, 32'h40, "pre_clr_sp");
    tick();
    mode_cmd = 2'd3; wr_data = 32'd9; sp_next = 32'h60; pc_next = 32'h54;
    expect_at(1, SIG_SP,  32'hFFFF_FFFF, "clr_sp");
    expect_at(1, SIG_PC,  32'h54,        "clr_pc");
    expect_at(1, SIG_RDA, byp_r0,        "clr_r0_same_edge");
    tick();
    idle_inputs();
    expect_at(1, SIG_RDA, 32'd8192, "clr_r0");
    tick();

    // Branch select.
    enable = 1'b1; branch = 1'b1; branch_target = 32'hDEAD_0000;
    pc_next = 32'h58; sp_next = 32'hFFFF_FFFF;
    expect_at(1, SIG_PC, 32'hDEAD_0000, "branch_pc");
    tick();
    idle_inputs();

    // LR written in the entering commit is overwritten by the save.
    enable = 1'b1; mode_cmd = 2'd1; wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h1234;
    pc_next = 32'h60; sp_next = 32'hFFFF_FFFF; rd_addr_b = 4'd13;
    expect_at(2, SIG_RDB,  32'h1234, "lr_commit_wr");
    expect_at(3, SIG_RDB,  32'h60,   "lr_save_wins");
    expect_at(3, SIG_PRIV, 32'd1,    "lr_case_priv");
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();

    if (sb.size() != 0) begin
      failures += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
